hazard_stall_ctrl: RTL and testbench

Sequencing controller for the ID→EX pipeline register and the fetch stage. It detects load-use hazards, multi-cycle multiply/divide occupancy and taken-branch redirects. From these it generates hold, bubble and flush controls, so the ID/EX register either captures, holds, or is loaded with a NOP. It sits beside the ID/EX register, takes decoded register fields from ID and status from EX, and drives the PC, IF/ID and ID/EX enables.

---
 rtl/hazard_stall_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// ID/EX and fetch sequencing: load-use stalls, multi-cycle MDU occupancy, branch flushes.
// Define HAZARD_MDU_STALL_EN to compile in the MDU_BUSY state and its occupancy counter.
module hazard_stall_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_is_load,
  input  logic                   ex_mdu_start,
  input  logic                   ex_branch_taken,
  output logic                   pc_hold,
  output logic                   ifid_hold,
  output logic                   idex_bubble,
  output logic                   idex_hold,
  output logic                   ifid_flush,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MDU_BUSY} state_t;

  state_t                 state, state_next;
  logic                   hazard_lu;
  logic [STALL_CNT_W-1:0] stall_cnt;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  assign hazard_lu = ex_is_load && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef HAZARD_MDU_STALL_EN
  localparam int CNT_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_next;
  end
`else
  logic [1:0] mdu_unused;
  assign mdu_unused = {ex_mdu_start, MDU_LATENCY[0]};
`endif

  always_comb begin
    state_next  = state;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    ifid_flush  = 1'b0;
`ifdef HAZARD_MDU_STALL_EN
    cnt_next    = cnt;
`endif
    if (!reset) begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
`ifdef HAZARD_MDU_STALL_EN
          end else if (ex_mdu_start) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            idex_hold = 1'b1;
            cnt_next  = CNT_W'(MDU_LATENCY - 2);
            // A two-cycle MDU is fully covered by its start cycle.
            if (MDU_LATENCY > 2) state_next = MDU_BUSY;
`endif
          end else if (hazard_lu) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
        end
`ifdef HAZARD_MDU_STALL_EN
        MDU_BUSY: begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          idex_hold = 1'b1;
          cnt_next  = cnt - 1'b1;
          if ((cnt == CNT_W'(1)) || (cnt == '0)) state_next = RUN;
        end
`endif
        default: state_next = RUN;
      endcase
      if (idex_bubble) idex_hold = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      if (pc_hold) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; expectations follow the HAZARD_MDU_STALL_EN build setting.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic        ex_is_load = 1'b0, ex_mdu_start = 1'b0, ex_branch_taken = 1'b0;
  logic        pc_hold, ifid_hold, idex_bubble, idex_hold, ifid_flush;
  logic [15:0] stall_cycles;
  logic [4:0]  outs;

  int tests = 0;
  int failed = 0;

`ifdef HAZARD_MDU_STALL_EN
  localparam int MDU_STALLS = 3;
  localparam logic [4:0] MDU_OUTS = 5'b11010;
`else
  localparam int MDU_STALLS = 0;
  localparam logic [4:0] MDU_OUTS = 5'b00000;
`endif

  hazard_stall_ctrl #(.MDU_LATENCY(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mdu_start(ex_mdu_start),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
    .idex_hold(idex_hold), .ifid_flush(ifid_flush), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // outs = {pc_hold, ifid_hold, idex_bubble, idex_hold, ifid_flush}
  assign outs = {pc_hold, ifid_hold, idex_bubble, idex_hold, ifid_flush};

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_mdu_start = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic load_use_rs2();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    load_use_rs2();
    ex_branch_taken = 1'b1;
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL reset_outs: got %b expected 00000", outs);
    end
    @(negedge clk);
    tests++;
    if (stall_cycles !== 16'd0) begin
      failed++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
    end
    idle_inputs();
    reset = 1'b0;
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL reset_idle_outs: got %b expected 00000", outs);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    load_use_rs2();
    #1;
    tests++;
    if (outs !== 5'b11100) begin
      failed++; $display("FAIL lu_rs2_outs: got %b expected 11100", outs);
    end
    @(negedge clk);
    tests++;
    if (stall_cycles !== 16'd1) begin
      failed++; $display("FAIL lu_rs2_stall: got %0d expected 1", stall_cycles);
    end
    ex_is_load = 1'b0;
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL lu_load_in_mem: got %b expected 00000", outs);
    end
    @(negedge clk);
    idle_inputs();
    ex_is_load = 1'b1; ex_rd = 5'd17; id_rs1 = 5'd17; id_use_rs1 = 1'b1; id_rs2 = 5'd3;
    #1;
    tests++;
    if (outs !== 5'b11100) begin
      failed++; $display("FAIL lu_rs1_outs: got %b expected 11100", outs);
    end
    @(negedge clk);
    tests++;
    if (stall_cycles !== 16'd2) begin
      failed++; $display("FAIL lu_rs1_stall: got %0d expected 2", stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_no_hazard();
    @(negedge clk);
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL nohz_r0: got %b expected 00000", outs);
    end
    @(negedge clk);
    idle_inputs();
    load_use_rs2();
    id_use_rs2 = 1'b0;
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL nohz_unused_rs2: got %b expected 00000", outs);
    end
    @(negedge clk);
    idle_inputs();
    ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL nohz_not_load: got %b expected 00000", outs);
    end
    @(negedge clk);
    tests++;
    if (stall_cycles !== 16'd2) begin
      failed++; $display("FAIL nohz_stall: got %0d expected 2", stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_mdu();
    @(negedge clk);
    ex_mdu_start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (outs !== MDU_OUTS) begin
        failed++; $display("FAIL mdu_hold_c%0d: got %b expected %b", c, outs, MDU_OUTS);
      end
      @(negedge clk);
      ex_mdu_start = 1'b0;
    end
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL mdu_release: got %b expected 00000", outs);
    end
    tests++;
    if (stall_cycles !== 16'(2 + MDU_STALLS)) begin
      failed++; $display("FAIL mdu_stall: got %0d expected %0d", stall_cycles, 2 + MDU_STALLS);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    load_use_rs2();
    ex_mdu_start = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    tests++;
    if (outs !== 5'b00101) begin
      failed++; $display("FAIL branch_outs: got %b expected 00101", outs);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL branch_after: got %b expected 00000", outs);
    end
    tests++;
    if (stall_cycles !== 16'(2 + MDU_STALLS)) begin
      failed++; $display("FAIL branch_stall: got %0d expected %0d", stall_cycles, 2 + MDU_STALLS);
    end
  endtask

  task automatic test_reset_mid_mdu();
    @(negedge clk);
    ex_mdu_start = 1'b1;
    @(negedge clk);
    ex_mdu_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL rstmdu_during: got %b expected 00000", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (outs !== 5'b00000) begin
      failed++; $display("FAIL rstmdu_run: got %b expected 00000", outs);
    end
    tests++;
    if (stall_cycles !== 16'd0) begin
      failed++; $display("FAIL rstmdu_stall: got %0d expected 0", stall_cycles);
    end
    @(negedge clk);
    load_use_rs2();
    #1;
    tests++;
    if (outs !== 5'b11100) begin
      failed++; $display("FAIL rstmdu_lu_after: got %b expected 11100", outs);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    load_use_rs2();
    repeat (65534) @(posedge clk);
    #1;
    tests++;
    if (stall_cycles !== 16'hFFFE) begin
      failed++; $display("FAIL sat_before: got %h expected fffe", stall_cycles);
    end
    repeat (7) @(posedge clk);
    #1;
    tests++;
    if (stall_cycles !== 16'hFFFF) begin
      failed++; $display("FAIL sat_hold: got %h expected ffff", stall_cycles);
    end
    tests++;
    if (outs !== 5'b11100) begin
      failed++; $display("FAIL sat_outs: got %b expected 11100", outs);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mdu();
    test_branch();
    test_reset_mid_mdu();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
